// File: rtl/rec_frame_sched_if.sv
// rtl/rec_frame_sched_if.sv - Capture control, frame-buffer write and consumer handshake bundle for rec_frame_sched.
// o_frame_peak exists only when REC_FRAME_PEAK_EN is defined.
interface rec_frame_sched_if #(
  parameter int ADDR_W = 8
);
  logic              i_start;
  logic              i_stop;
  logic              o_record;
  logic              i_adc_done;
  logic [15:0]       i_adc_data;
  logic              o_wr_en;
  logic              o_wr_bank;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [15:0]       o_wr_data;
  logic              o_frame_valid;
  logic              o_frame_bank;
  logic              i_frame_ack;
  logic              o_overrun;
  logic [15:0]       o_frame_cnt;
  logic [1:0]        o_state;
`ifdef REC_FRAME_PEAK_EN
  logic [15:0]       o_frame_peak;
`endif

  modport master (
`ifdef REC_FRAME_PEAK_EN
    input  o_frame_peak,
`endif
    output i_start, i_stop, i_adc_done, i_adc_data, i_frame_ack,
    input  o_record, o_wr_en, o_wr_bank, o_wr_addr, o_wr_data,
    input  o_frame_valid, o_frame_bank, o_overrun, o_frame_cnt, o_state
  );

  modport slave (
`ifdef REC_FRAME_PEAK_EN
    output o_frame_peak,
`endif
    input  i_start, i_stop, i_adc_done, i_adc_data, i_frame_ack,
    output o_record, o_wr_en, o_wr_bank, o_wr_addr, o_wr_data,
    output o_frame_valid, o_frame_bank, o_overrun, o_frame_cnt, o_state
  );
endinterface

// File: rtl/rec_frame_sched.sv
// rtl/rec_frame_sched.sv - ADC capture sequencer writing a ping-pong frame buffer and handing full banks to a consumer.
// Optional per-frame peak magnitude output under REC_FRAME_PEAK_EN.
module rec_frame_sched #(
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = 8,
  parameter int DECIM     = 1
) (
  input  logic             i_BCLK,
  input  logic             i_rst_n,
  rec_frame_sched_if.slave bus
);
  localparam int DEC_W = $clog2(DECIM + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [DEC_W-1:0]  DEC_RELOAD = DEC_W'(DECIM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_FILL  = 2'd2,
    S_STALL = 2'd3
  } state_t;

  state_t            state_q;
  logic              record_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [DEC_W-1:0]  dec_q;
  logic              wr_bank_q;
  logic [1:0]        full_q;
  logic              rd_bank_q;
  logic              wr_en_q;
  logic              wr_bank_o_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [15:0]       wr_data_q;
  logic              overrun_q;
  logic [15:0]       frame_cnt_q;

  logic       ack_eff;
  logic       dec_step;
  logic       pulse_acc;
  logic       write_go;
  logic       last_wr;
  logic [1:0] full_d;

  // Ack clears the offered bank and completion sets the bank just written; both fold into full_d
  always_comb begin
    ack_eff   = bus.i_frame_ack && (full_q != 2'b00);
    dec_step  = bus.i_adc_done && ((state_q == S_FILL) || (state_q == S_STALL));
    pulse_acc = dec_step && (dec_q == '0);
    write_go  = pulse_acc && (state_q == S_FILL) && !bus.i_stop;
    last_wr   = write_go && (ptr_q == LAST_ADDR);
    full_d    = full_q;
    if (ack_eff) full_d[rd_bank_q] = 1'b0;
    if (last_wr) full_d[wr_bank_q] = 1'b1;
  end

`ifdef REC_FRAME_PEAK_EN
  logic [15:0] run_peak_q;
  logic [15:0] frame_peak_q;
  logic [15:0] mag;
  logic [15:0] peak_cand;

  always_comb begin
    if (!bus.i_adc_data[15])             mag = bus.i_adc_data;
    else if (bus.i_adc_data == 16'h8000) mag = 16'h7FFF;
    else                                 mag = ~bus.i_adc_data + 16'd1;
    peak_cand = (mag > run_peak_q) ? mag : run_peak_q;
  end

  assign bus.o_frame_peak = frame_peak_q;
`endif

  always_ff @(posedge i_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      record_q    <= 1'b0;
      ptr_q       <= '0;
      dec_q       <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      rd_bank_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_bank_o_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
`ifdef REC_FRAME_PEAK_EN
      run_peak_q   <= '0;
      frame_peak_q <= '0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      full_q  <= full_d;
      if (ack_eff) rd_bank_q <= ~rd_bank_q;
      if (dec_step) dec_q <= (dec_q == '0) ? DEC_RELOAD : dec_q - 1'b1;

      if (bus.i_stop && (state_q != S_IDLE)) begin
        state_q  <= S_IDLE;
        record_q <= 1'b0;
        ptr_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (bus.i_start && !bus.i_stop) begin
              state_q   <= S_ARM;
              record_q  <= 1'b1;
              overrun_q <= 1'b0;
              ptr_q     <= '0;
              dec_q     <= '0;
`ifdef REC_FRAME_PEAK_EN
              run_peak_q <= '0;
`endif
            end
          end
          // A restart onto a bank still held by the consumer waits rather than overwriting it
          S_ARM: state_q <= full_d[wr_bank_q] ? S_STALL : S_FILL;
          S_FILL: begin
            if (write_go) begin
              wr_en_q     <= 1'b1;
              wr_bank_o_q <= wr_bank_q;
              wr_addr_q   <= ptr_q;
              wr_data_q   <= bus.i_adc_data;
              if (last_wr) begin
                ptr_q       <= '0;
                wr_bank_q   <= ~wr_bank_q;
                frame_cnt_q <= frame_cnt_q + 16'd1;
                if (full_d[~wr_bank_q]) state_q <= S_STALL;
`ifdef REC_FRAME_PEAK_EN
                frame_peak_q <= peak_cand;
                run_peak_q   <= '0;
`endif
              end else begin
                ptr_q <= ptr_q + 1'b1;
`ifdef REC_FRAME_PEAK_EN
                run_peak_q <= peak_cand;
`endif
              end
            end
          end
          S_STALL: begin
            if (pulse_acc) overrun_q <= 1'b1;
            if (!full_d[wr_bank_q]) state_q <= S_FILL;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_record      = record_q;
  assign bus.o_wr_en       = wr_en_q;
  assign bus.o_wr_bank     = wr_bank_o_q;
  assign bus.o_wr_addr     = wr_addr_q;
  assign bus.o_wr_data     = wr_data_q;
  assign bus.o_frame_valid = (full_q != 2'b00);
  assign bus.o_frame_bank  = rd_bank_q;
  assign bus.o_overrun     = overrun_q;
  assign bus.o_frame_cnt   = frame_cnt_q;
  assign bus.o_state       = state_q;
endmodule

// File: tb/tb_rec_frame_sched.sv
// tb/tb_rec_frame_sched.sv - Directed self-checking bench for rec_frame_sched (DECIM=1 and DECIM=4 instances).
// Peak checks are compiled in when REC_FRAME_PEAK_EN is defined.
module tb_rec_frame_sched;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  rec_frame_sched_if #(.ADDR_W(8)) bus_a ();
  rec_frame_sched_if #(.ADDR_W(8)) bus_d ();

  rec_frame_sched #(.FRAME_LEN(256), .ADDR_W(8), .DECIM(1)) u_dut_a (
    .i_BCLK (clk),
    .i_rst_n(rst_n),
    .bus    (bus_a.slave)
  );

  rec_frame_sched #(.FRAME_LEN(256), .ADDR_W(8), .DECIM(4)) u_dut_d (
    .i_BCLK (clk),
    .i_rst_n(rst_n),
    .bus    (bus_d.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wv(input logic en, input logic bank, input logic [7:0] addr,
                                     input logic [15:0] data);
    return {6'd0, en, bank, addr, data};
  endfunction

  function automatic logic [31:0] obs_a();
    return {6'd0, bus_a.o_wr_en, bus_a.o_wr_bank, bus_a.o_wr_addr, bus_a.o_wr_data};
  endfunction

  task automatic send_a(input logic [15:0] d, input logic ack);
    bus_a.i_adc_done  = 1'b1;
    bus_a.i_adc_data  = d;
    bus_a.i_frame_ack = ack;
    tick();
    bus_a.i_adc_done  = 1'b0;
    bus_a.i_frame_ack = 1'b0;
  endtask

  task automatic run_a(input logic bank, input int a0, input int n, input int dbase);
    for (int i = 0; i < n; i++) begin
      send_a(16'(dbase + i), 1'b0);
      chk("wr_a", obs_a(), wv(1'b1, bank, 8'(a0 + i), 16'(dbase + i)));
    end
  endtask

  task automatic ack_a();
    bus_a.i_frame_ack = 1'b1;
    tick();
    bus_a.i_frame_ack = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    {bus_a.i_start, bus_a.i_stop, bus_a.i_adc_done, bus_a.i_frame_ack} = 4'b0;
    {bus_d.i_start, bus_d.i_stop, bus_d.i_adc_done, bus_d.i_frame_ack} = 4'b0;
    bus_a.i_adc_data = '0;
    bus_d.i_adc_data = '0;
    tick();
    tick();
    chk("rst_state", 32'(bus_a.o_state), 32'd0);
    chk("rst_record", 32'(bus_a.o_record), 32'd0);
    chk("rst_valid", 32'(bus_a.o_frame_valid), 32'd0);
    chk("rst_cnt", 32'(bus_a.o_frame_cnt), 32'd0);
    chk("rst_wr", obs_a(), 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame 1: bank 0, data = index
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    chk("arm_state", 32'(bus_a.o_state), 32'd1);
    chk("arm_record", 32'(bus_a.o_record), 32'd1);
    tick();
    chk("fill_state", 32'(bus_a.o_state), 32'd2);
    run_a(1'b0, 0, 255, 0);
    chk("pre_full_valid", 32'(bus_a.o_frame_valid), 32'd0);
    run_a(1'b0, 255, 1, 255);
    chk("f1_valid", 32'(bus_a.o_frame_valid), 32'd1);
    chk("f1_bank", 32'(bus_a.o_frame_bank), 32'd0);
    chk("f1_cnt", 32'(bus_a.o_frame_cnt), 32'd1);
    send_a(16'h1234, 1'b0);
    chk("b1_first", obs_a(), wv(1'b1, 1'b1, 8'd0, 16'h1234));
    tick();
    chk("wr_en_drop", 32'(bus_a.o_wr_en), 32'd0);

    // Fill bank 1 with bank 0 unacked -> STALL
    run_a(1'b1, 1, 255, 1);
    chk("f2_cnt", 32'(bus_a.o_frame_cnt), 32'd2);
    chk("stall_state", 32'(bus_a.o_state), 32'd3);
    chk("stall_record", 32'(bus_a.o_record), 32'd1);
    chk("stall_ovr0", 32'(bus_a.o_overrun), 32'd0);
    send_a(16'd77, 1'b0);
    chk("stall_nowr", 32'(bus_a.o_wr_en), 32'd0);
    chk("stall_ovr1", 32'(bus_a.o_overrun), 32'd1);
    ack_a();
    chk("resume_state", 32'(bus_a.o_state), 32'd2);
    chk("resume_fbank", 32'(bus_a.o_frame_bank), 32'd1);
    chk("resume_valid", 32'(bus_a.o_frame_valid), 32'd1);
    send_a(16'd500, 1'b0);
    chk("resume_wr", obs_a(), wv(1'b1, 1'b0, 8'd0, 16'd500));

    // Stop mid-frame in bank 1 while bank 0 is offered
    ack_a();
    chk("ack_b1_valid", 32'(bus_a.o_frame_valid), 32'd0);
    run_a(1'b0, 1, 255, 1000);
    chk("f3_cnt", 32'(bus_a.o_frame_cnt), 32'd3);
    chk("f3_fbank", 32'(bus_a.o_frame_bank), 32'd0);
    run_a(1'b1, 0, 100, 2000);
    bus_a.i_stop = 1'b1;
    tick();
    bus_a.i_stop = 1'b0;
    chk("stop_state", 32'(bus_a.o_state), 32'd0);
    chk("stop_record", 32'(bus_a.o_record), 32'd0);
    chk("stop_valid", 32'(bus_a.o_frame_valid), 32'd1);
    chk("stop_fbank", 32'(bus_a.o_frame_bank), 32'd0);
    chk("stop_ovr_kept", 32'(bus_a.o_overrun), 32'd1);
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    chk("restart_ovr", 32'(bus_a.o_overrun), 32'd0);
    tick();
    send_a(16'd42, 1'b0);
    chk("restart_wr", obs_a(), wv(1'b1, 1'b1, 8'd0, 16'd42));

    // Ack coincides with the last write of bank 1
    run_a(1'b1, 1, 254, 3000);
    send_a(16'd9999, 1'b1);
    chk("coinc_wr", obs_a(), wv(1'b1, 1'b1, 8'd255, 16'd9999));
    chk("coinc_state", 32'(bus_a.o_state), 32'd2);
    chk("coinc_ovr", 32'(bus_a.o_overrun), 32'd0);
    chk("coinc_valid", 32'(bus_a.o_frame_valid), 32'd1);
    chk("coinc_fbank", 32'(bus_a.o_frame_bank), 32'd1);
    chk("coinc_cnt", 32'(bus_a.o_frame_cnt), 32'd4);

    // Peak frames: bank 0 holds -32768 and 1000, bank 1 all fives
    ack_a();
    for (int i = 0; i < 256; i++) begin
      send_a((i == 0) ? 16'h8000 : (i == 1) ? 16'd1000 : 16'd0, 1'b0);
    end
`ifdef REC_FRAME_PEAK_EN
    chk("peak_sat", 32'(bus_a.o_frame_peak), 32'd32767);
`endif
    for (int i = 0; i < 256; i++) begin
      send_a(16'd5, 1'b0);
    end
`ifdef REC_FRAME_PEAK_EN
    chk("peak_five", 32'(bus_a.o_frame_peak), 32'd5);
`endif
    chk("f6_cnt", 32'(bus_a.o_frame_cnt), 32'd6);
    chk("f6_state", 32'(bus_a.o_state), 32'd3);

    // Start and stop together: stop wins
    bus_a.i_start = 1'b1;
    bus_a.i_stop  = 1'b1;
    tick();
    chk("ss_stall", 32'(bus_a.o_state), 32'd0);
    tick();
    chk("ss_idle", 32'(bus_a.o_state), 32'd0);
    bus_a.i_start = 1'b0;
    bus_a.i_stop  = 1'b0;

    // DECIM=4 instance: ARM pulse ignored, then keep pulses 0,4,8,...
    bus_d.i_start = 1'b1;
    tick();
    bus_d.i_start    = 1'b0;
    bus_d.i_adc_done = 1'b1;
    bus_d.i_adc_data = 16'hDEAD;
    tick();
    bus_d.i_adc_done = 1'b0;
    chk("d_arm_ignored", 32'(bus_d.o_wr_en), 32'd0);
    chk("d_fill_state", 32'(bus_d.o_state), 32'd2);
    for (int i = 0; i < 1024; i++) begin
      bus_d.i_adc_done = 1'b1;
      bus_d.i_adc_data = 16'(i);
      tick();
      bus_d.i_adc_done = 1'b0;
      if ((i % 4) == 0)
        chk("d_wr", {6'd0, bus_d.o_wr_en, bus_d.o_wr_bank, bus_d.o_wr_addr, bus_d.o_wr_data},
            wv(1'b1, 1'b0, 8'(i / 4), 16'(i)));
      else
        chk("d_skip", 32'(bus_d.o_wr_en), 32'd0);
    end
    chk("d_cnt", 32'(bus_d.o_frame_cnt), 32'd1);
    chk("d_valid", 32'(bus_d.o_frame_valid), 32'd1);
    chk("d_fbank", 32'(bus_d.o_frame_bank), 32'd0);

    // Mid-frame asynchronous reset
    ack_a();
    bus_a.i_start = 1'b1;
    tick();
    bus_a.i_start = 1'b0;
    tick();
    run_a(1'b0, 0, 10, 7);
    rst_n = 1'b0;
    #2;
    chk("ar_state", 32'(bus_a.o_state), 32'd0);
    chk("ar_record", 32'(bus_a.o_record), 32'd0);
    chk("ar_wr", obs_a(), 32'd0);
    chk("ar_valid", 32'(bus_a.o_frame_valid), 32'd0);
    chk("ar_fbank", 32'(bus_a.o_frame_bank), 32'd0);
    chk("ar_cnt", 32'(bus_a.o_frame_cnt), 32'd0);
    chk("ar_ovr", 32'(bus_a.o_overrun), 32'd0);
    chk("ar_d_cnt", 32'(bus_d.o_frame_cnt), 32'd0);
`ifdef REC_FRAME_PEAK_EN
    chk("ar_peak", 32'(bus_a.o_frame_peak), 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rec_frame_sched.md
Name: rec_frame_sched

Overview:
- Sequences the ADC capture path for the visualiser.
- Drives the record-enable of the serial ADC capture controller and collects its 16-bit left-channel samples.
- Writes accepted samples into a two-bank (ping-pong) frame buffer, FRAME_LEN samples per bank.
- Hands each completed bank to the downstream FFT/display consumer with a valid/ack handshake, so capture and processing overlap.

Parameters:
- FRAME_LEN, 256: samples per frame; power of two, 16..4096.
- ADDR_W, 8: write-address width; must equal log2(FRAME_LEN).
- DECIM, 1: keep 1 of every DECIM capture pulses; 1..16.

Ports:
- i_BCLK  in  1  sole clock, the audio bit clock also used by the ADC capture controller.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; begin capture.
- i_stop  in  1  one-cycle pulse; end capture.
- o_record  out  1  record enable to the ADC capture controller.
- i_adc_done  in  1  one-cycle sample-ready pulse from the capture controller.
- i_adc_data  in  16  sample, valid when i_adc_done=1.
- o_wr_en  out  1  frame-buffer write strobe.
- o_wr_bank  out  1  bank being written.
- o_wr_addr  out  ADDR_W  sample index within the bank.
- o_wr_data  out  16  sample to write.
- o_frame_valid  out  1  a full bank is ready for the consumer.
- o_frame_bank  out  1  bank offered to the consumer.
- i_frame_ack  in  1  consumer has finished with o_frame_bank.
- o_overrun  out  1  sticky flag; samples were dropped.
- o_frame_cnt  out  16  completed frames, wraps.
- o_state  out  2  current state: 0 IDLE, 1 ARM, 2 FILL, 3 STALL.

Behaviour:
Reset (i_rst_n low, asynchronous):
- State IDLE; all outputs 0.
- Bank-full flags = 00; write pointer, decimation counter, wr_bank = 0.

State machine (one transition per i_BCLK edge):
- IDLE: o_record=0. On i_start go to ARM. The ARM entry clears o_overrun and the write pointer but not the full flags.
- ARM: o_record=1. Go to FILL next cycle. Any i_adc_done pulse arriving in ARM is ignored.
- FILL: o_record=1.
  - Each i_adc_done passes through the decimation counter. The first pulse after ARM is accepted, then every DECIM-th pulse after it.
  - An accepted sample is written with latency 1: o_wr_en=1 for one cycle, o_wr_data=sample, o_wr_addr=pointer, o_wr_bank=wr_bank. The pointer then increments.
  - When the write at address FRAME_LEN-1 is issued: set full[wr_bank], increment o_frame_cnt, reset the pointer to 0, toggle wr_bank.
  - If the new wr_bank is already full, go to STALL.
- STALL: o_record stays 1, the ADC keeps running, and no writes are issued.
  - Every accepted sample sets o_overrun.
  - When full[wr_bank] clears, return to FILL at pointer 0.
- i_stop in ARM, FILL or STALL: go to IDLE next cycle and drop o_record.
  - The partial frame is discarded and the pointer reset.
  - Full banks are kept and remain offered to the consumer.
- i_start outside IDLE is ignored.
- i_start and i_stop in the same cycle: stop wins.

Consumer handshake:
- o_frame_valid = (full != 00).
- o_frame_bank = the oldest full bank. This is tracked by a read-bank register that toggles on each ack.
- i_frame_ack while o_frame_valid=1 clears full[o_frame_bank] on the next edge. i_frame_ack while o_frame_valid=0 is ignored.
- Ack and frame completion in the same cycle: both take effect. Set-on-complete and clear-on-ack apply to different banks. If STALL would be entered on a bank being acked that same cycle, go to FILL instead.
- o_frame_bank must stay stable while o_frame_valid=1 until it is acked.

Width and wrap rules:
- o_frame_cnt wraps from 65535 to 0.
- The decimation counter is ceil(log2(DECIM+1)) bits wide.
- The pointer wraps exactly at FRAME_LEN, with no extra write.

Optional Feature:
- Macro: REC_FRAME_PEAK_EN.
- When defined: adds output o_frame_peak (16 bits).
  - Tracks the largest |sample| of the frame being written. Samples are two's complement; -32768 saturates to 32767.
  - The value is latched into o_frame_peak in the same cycle the full flag is set, and is held until the next frame completes.
  - The running peak resets at ARM entry and at every frame boundary. o_frame_peak resets to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, i_start, then 256 i_adc_done pulses (data = index) with DECIM=1 -> writes to bank 0 at addr 0..255 with data 0..255. o_frame_valid=1, o_frame_bank=0, o_frame_cnt=1. The next sample goes to bank 1, addr 0.
2. DECIM=4, 1024 done pulses -> exactly 256 writes, taking pulses 0, 4, 8, ...; one frame completes.
3. Fill both banks without ack -> STALL, o_record=1, no o_wr_en, o_overrun=1 after the next pulse. Ack bank 0 -> FILL resumes at bank 0, addr 0, and o_frame_bank=1.
4. i_stop at addr 100 of bank 1 with bank 0 full -> o_record=0 next cycle; bank 0 still offered. i_start -> writing restarts at bank 1, addr 0, with o_overrun cleared.
5. Ack on the same cycle as the frame-255 write, with the other bank pending -> no STALL, no overrun; o_frame_valid remains 1 for the new bank.
6. With REC_FRAME_PEAK_EN: frame containing -32768 and 1000 -> o_frame_peak=32767. Next frame of all 5 -> o_frame_peak=5. Assert i_rst_n low mid-frame -> all outputs 0 immediately.
